mem_wb_stage: RTL and testbench

//  MEM->WB pipeline register plus writeback datapath of the 5-stage MIPS core; feeds register_file.
//  - Captures M-stage results; sign/zero-extends load data.
//  - Drives the register-file write port: A3_W, RegWrW, busW, busW_selW, PC_W.
//  - Exports a W-stage bypass value for the hazard unit and a retired-instruction counter.

---
 rtl/mem_wb_stage_pkg.sv | 15 +
 rtl/mem_wb_stage_load_ext.sv | 38 +++
 rtl/mem_wb_stage.sv | 113 +++++++++++
 tb/tb_mem_wb_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared writeback definitions: load-type codes and the link offset.
// Imported by the instruction decoder and by the MEM->WB stage.
package mem_wb_stage_pkg;

    localparam int LINK_OFS_DEF = 8;

    typedef enum logic [2:0] {
        LD_LW  = 3'd0,
        LD_LBU = 3'd1,
        LD_LB  = 3'd2,
        LD_LHU = 3'd3,
        LD_LH  = 3'd4
    } ld_type_e;

endpackage

// File: rtl/mem_wb_stage_load_ext.sv
// Combinational load extender: selects a byte/half lane of a little-endian word
// and sign- or zero-extends it. Codes 5-7 fall back to a full-word load.
module load_ext
    import mem_wb_stage_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [2:0]    ld_type,
    input  logic [1:0]    addr_lo,
    input  logic [DW-1:0] word,
    output logic [DW-1:0] ext_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    function automatic logic [DW-1:0] ext8(input logic [7:0] b, input logic sgn);
        return {{(DW-8){sgn & b[7]}}, b};
    endfunction

    function automatic logic [DW-1:0] ext16(input logic [15:0] h, input logic sgn);
        return {{(DW-16){sgn & h[15]}}, h};
    endfunction

    always_comb begin
        byte_sel = word[8*addr_lo +: 8];
        // Halfword lane depends only on bit 1; misalignment is not trapped here.
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
        case (ld_type)
            LD_LBU:  ext_data = ext8(byte_sel, 1'b0);
            LD_LB:   ext_data = ext8(byte_sel, 1'b1);
            LD_LHU:  ext_data = ext16(half_sel, 1'b0);
            LD_LH:   ext_data = ext16(half_sel, 1'b1);
            default: ext_data = word;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register and writeback datapath: drives the register-file
// write port, a W-stage bypass value and a retired-instruction counter.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int LINK_OFS = LINK_OFS_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          flush,
    input  logic          valid_M,
    input  logic [DW-1:0] PC_M,
    input  logic [AW-1:0] A3_M,
    input  logic          RegWrM,
    input  logic          busW_selM,
    input  logic          memtoreg_M,
    input  logic [2:0]    ld_type_M,
    input  logic [1:0]    addr_lo_M,
    input  logic [DW-1:0] alu_M,
    input  logic [DW-1:0] dm_rdata_M,
    output logic [AW-1:0] A3_W,
    output logic          RegWrW,
    output logic [DW-1:0] busW,
    output logic          busW_selW,
    output logic [DW-1:0] PC_W,
    output logic [DW-1:0] fwd_data_W,
    output logic          fwd_en_W,
    output logic [31:0]   retired_cnt
);

    logic          valid_w;
    logic          regwr_w;
    logic [AW-1:0] a3_w;
    logic          sel_w;
    logic [DW-1:0] pc_w;
    logic          memtoreg_w;
    logic [2:0]    ld_type_w;
    logic [1:0]    addr_lo_w;
    logic [DW-1:0] alu_w;
    logic [DW-1:0] rdata_w;
    logic [31:0]   retired_q;
    logic [DW-1:0] load_w;

    // M -> W boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_w    <= 1'b0;
            regwr_w    <= 1'b0;
            a3_w       <= '0;
            sel_w      <= 1'b0;
            pc_w       <= '0;
            memtoreg_w <= 1'b0;
            ld_type_w  <= '0;
            addr_lo_w  <= '0;
            alu_w      <= '0;
            rdata_w    <= '0;
        end else if (flush) begin
            valid_w    <= 1'b0;
            regwr_w    <= 1'b0;
            a3_w       <= '0;
            sel_w      <= 1'b0;
            pc_w       <= '0;
            memtoreg_w <= 1'b0;
            ld_type_w  <= '0;
            addr_lo_w  <= '0;
            alu_w      <= '0;
            rdata_w    <= '0;
        end else if (en) begin
            valid_w    <= valid_M;
            regwr_w    <= RegWrM & valid_M;
            a3_w       <= A3_M;
            sel_w      <= busW_selM;
            pc_w       <= PC_M;
            memtoreg_w <= memtoreg_M;
            ld_type_w  <= ld_type_M;
            addr_lo_w  <= addr_lo_M;
            alu_w      <= alu_M;
            rdata_w    <= dm_rdata_M;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
        end else if (en && !flush && valid_M) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    // W stage: extension, writeback mux and bypass
    load_ext #(.DW(DW)) u_load_ext (
        .ld_type  (ld_type_w),
        .addr_lo  (addr_lo_w),
        .word     (rdata_w),
        .ext_data (load_w)
    );

    always_comb begin
        A3_W        = a3_w;
        RegWrW      = regwr_w & valid_w;
        busW        = memtoreg_w ? load_w : alu_w;
        busW_selW   = sel_w;
        PC_W        = pc_w;
        // Bypass must match what register_file stores, including the link offset it adds.
        fwd_data_W  = sel_w ? (pc_w + DW'(LINK_OFS)) : busW;
        fwd_en_W    = RegWrW && (a3_w != '0);
        retired_cnt = retired_q;
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized and directed bench for mem_wb_stage against a behavioural
// writeback model kept in plain variables.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        flush;
    logic        valid_M;
    logic [31:0] PC_M;
    logic [4:0]  A3_M;
    logic        RegWrM;
    logic        busW_selM;
    logic        memtoreg_M;
    logic [2:0]  ld_type_M;
    logic [1:0]  addr_lo_M;
    logic [31:0] alu_M;
    logic [31:0] dm_rdata_M;
    logic [4:0]  A3_W;
    logic        RegWrW;
    logic [31:0] busW;
    logic        busW_selW;
    logic [31:0] PC_W;
    logic [31:0] fwd_data_W;
    logic        fwd_en_W;
    logic [31:0] retired_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [4:0]  m_a3;
    logic        m_regwr;
    logic [31:0] m_busw;
    logic        m_sel;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    mem_wb_stage dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .flush       (flush),
        .valid_M     (valid_M),
        .PC_M        (PC_M),
        .A3_M        (A3_M),
        .RegWrM      (RegWrM),
        .busW_selM   (busW_selM),
        .memtoreg_M  (memtoreg_M),
        .ld_type_M   (ld_type_M),
        .addr_lo_M   (addr_lo_M),
        .alu_M       (alu_M),
        .dm_rdata_M  (dm_rdata_M),
        .A3_W        (A3_W),
        .RegWrW      (RegWrW),
        .busW        (busW),
        .busW_selW   (busW_selW),
        .PC_W        (PC_W),
        .fwd_data_W  (fwd_data_W),
        .fwd_en_W    (fwd_en_W),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [1:0] lo, input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * lo)) & 32'hFF;
        h = (lo >= 2) ? (w >> 16) : (w & 32'hFFFF);
        case (t)
            3'd1: return b;
            3'd2: return (b >= 128) ? (b - 32'd256) : b;
            3'd3: return h;
            3'd4: return (h >= 32768) ? (h - 32'd65536) : h;
            default: return w;
        endcase
    endfunction

    task automatic check_all(input string tag);
        logic [31:0] efwd;
        efwd = m_sel ? (m_pc + 32'd8) : m_busw;
        chk({tag, ".A3_W"}, {27'd0, A3_W}, {27'd0, m_a3});
        chk({tag, ".RegWrW"}, {31'd0, RegWrW}, {31'd0, m_regwr});
        chk({tag, ".busW"}, busW, m_busw);
        chk({tag, ".sel"}, {31'd0, busW_selW}, {31'd0, m_sel});
        chk({tag, ".PC_W"}, PC_W, m_pc);
        chk({tag, ".fwd_data"}, fwd_data_W, efwd);
        chk({tag, ".fwd_en"}, {31'd0, fwd_en_W}, {31'd0, (m_regwr && m_a3 != 0)});
        chk({tag, ".cnt"}, retired_cnt, m_cnt);
    endtask

    task automatic model_reset();
        m_a3 = 0; m_regwr = 0; m_busw = 0; m_sel = 0; m_pc = 0; m_cnt = 0;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else if (flush) begin
            m_a3 = 0; m_regwr = 0; m_busw = 0; m_sel = 0; m_pc = 0;
        end else if (en) begin
            m_a3    = A3_M;
            m_regwr = RegWrM & valid_M;
            m_busw  = memtoreg_M ? ref_load(ld_type_M, addr_lo_M, dm_rdata_M) : alu_M;
            m_sel   = busW_selM;
            m_pc    = PC_M;
            if (valid_M) m_cnt = m_cnt + 32'd1;
        end
        #1;
        check_all(tag);
    endtask

    task automatic set_idle();
        en = 1; flush = 0; valid_M = 0; PC_M = 0; A3_M = 0; RegWrM = 0;
        busW_selM = 0; memtoreg_M = 0; ld_type_M = 0; addr_lo_M = 0;
        alu_M = 0; dm_rdata_M = 0;
    endtask

    task automatic randomize_m();
        valid_M    = $urandom_range(0, 3) != 0;
        PC_M       = $urandom & 32'hFFFF_FFFC;
        A3_M       = 5'($urandom);
        RegWrM     = $urandom_range(0, 1) == 1;
        busW_selM  = $urandom_range(0, 4) == 0;
        memtoreg_M = $urandom_range(0, 1) == 1;
        ld_type_M  = 3'($urandom);
        addr_lo_M  = 2'($urandom);
        alu_M      = $urandom;
        dm_rdata_M = $urandom;
    endtask

    typedef struct {
        logic [2:0]  t;
        logic [1:0]  lo;
        logic [31:0] exp;
        string       tag;
    } ld_case_t;

    ld_case_t ld_cases[5] = '{
        '{3'd2, 2'd0, 32'hFFFF_FFF3, "LB0"},
        '{3'd1, 2'd2, 32'h0000_0091, "LBU2"},
        '{3'd4, 2'd2, 32'hFFFF_8091, "LH2"},
        '{3'd3, 2'd0, 32'h0000_A2F3, "LHU0"},
        '{3'd0, 2'd1, 32'h8091_A2F3, "LW"}
    };

    initial begin
        set_idle();
        reset = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("rst_init");
        @(negedge clk);
        reset = 0;

        // Fill W with live instructions, then reset asynchronously mid-cycle.
        for (int i = 0; i < 4; i++) begin
            randomize_m();
            valid_M = 1; RegWrM = 1; A3_M = 5'd7;
            step("prefill");
        end
        #2;
        reset = 1;
        #1;
        model_reset();
        check_all("rst_async");
        @(negedge clk);
        reset = 0;
        set_idle();
        step("rst_rel1");
        step("rst_rel2");

        // Load extension, one case per cycle.
        for (int i = 0; i < 5; i++) begin
            set_idle();
            valid_M = 1; RegWrM = 1; A3_M = 5'd4; memtoreg_M = 1;
            dm_rdata_M = 32'h8091_A2F3; alu_M = 32'hDEAD_BEEF;
            ld_type_M = ld_cases[i].t; addr_lo_M = ld_cases[i].lo;
            step(ld_cases[i].tag);
            chk({ld_cases[i].tag, ".abs"}, busW, ld_cases[i].exp);
        end

        // Link write.
        set_idle();
        valid_M = 1; busW_selM = 1; PC_M = 32'h0000_3000; A3_M = 5'd31; RegWrM = 1;
        step("link");
        chk("link.fwd_abs", fwd_data_W, 32'h0000_3008);
        chk("link.fwden_abs", {31'd0, fwd_en_W}, 32'd1);

        // Hold for three cycles with changing M inputs.
        for (int i = 0; i < 3; i++) begin
            randomize_m();
            en = 0; flush = 0;
            step("hold");
            chk("hold.fwd_abs", fwd_data_W, 32'h0000_3008);
        end
        randomize_m();
        valid_M = 1; RegWrM = 1; A3_M = 5'd9; en = 1; flush = 1;
        step("flush");

        // Write to $0.
        set_idle();
        valid_M = 1; A3_M = 0; RegWrM = 1; alu_M = 32'h1234_5678;
        step("zero");
        chk("zero.fwden_abs", {31'd0, fwd_en_W}, 32'd0);
        chk("zero.regwr_abs", {31'd0, RegWrW}, 32'd1);

        // Counter wrap.
        set_idle();
        en = 0;
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        m_cnt = 32'hFFFF_FFFF;
        step("wrap_pre");
        set_idle();
        valid_M = 1;
        step("wrap");
        chk("wrap.abs", retired_cnt, 32'd0);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            randomize_m();
            en    = $urandom_range(0, 3) != 0;
            flush = $urandom_range(0, 9) == 0;
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
